lab5_fetch: RTL

Instruction fetch stage for the 16-bit single-cycle processor. It sits directly upstream of the 128×16 instruction RAM. It owns the program counter, drives the RAM byte address, and presents the returned instruction word with a valid flag to the decode/execute logic. It also handles sequential advance, taken branches, stalls, end-of-program halt and a retired-fetch counter.

---
 rtl/lab5_fetch.sv | 71 +++++++
 1 files changed

// File: rtl/lab5_fetch.sv
// Instruction fetch stage: owns the PC, addresses the 128x16 instruction RAM and presents INSTR/VALID.
// Zero-cycle fetch latency; STALL holds the PC and drops VALID in the same cycle.
module lab5_fetch #(
  parameter logic [7:0] START_ADDR = 8'h00,
  parameter logic [7:0] LAST_ADDR  = 8'h52
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BR_TAKEN,
  input  logic [7:0]  BR_TARGET,
  output logic [7:0]  IMEM_ADDR,
  input  logic [15:0] IMEM_Q,
  output logic [15:0] INSTR,
  output logic [7:0]  PC_OUT,
  output logic [7:0]  PC_PLUS2,
  output logic        VALID,
  output logic        HALTED,
  output logic [15:0] FETCH_CNT
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  pc;
  logic [15:0] fetch_cnt;
  logic        retire;

  assign retire = (state == ST_RUN) && !STALL;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_LOAD;
      pc        <= START_ADDR & 8'hFE;
      fetch_cnt <= 16'h0000;
    end else begin
      if (retire && (fetch_cnt != 16'hFFFF))
        fetch_cnt <= fetch_cnt + 16'd1;
      case (state)
        // One settling cycle: the RAM is loaded while RESET is high.
        ST_LOAD: state <= ST_RUN;
        ST_RUN: begin
          // Stall beats branch; execute re-presents the branch afterwards.
          if (!STALL) begin
            if (BR_TAKEN)
              pc <= BR_TARGET & 8'hFE;
            else if (pc == LAST_ADDR)
              state <= ST_HALT;
            else
              pc <= pc + 8'd2;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_LOAD;
      endcase
    end
  end

  assign VALID     = retire;
  assign HALTED    = (state == ST_HALT);
  assign INSTR     = retire ? IMEM_Q : 16'h0000;
  assign IMEM_ADDR = pc;
  assign PC_OUT    = pc;
  assign PC_PLUS2  = pc + 8'd2;
  assign FETCH_CNT = fetch_cnt;

endmodule
